// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared types and default parameters for the two-requester
// multiplier arbiter.
//   NUM_REQ     - number of requesters sharing the multiplier core
//   DEF_OPW     - default operand width (product width is 2*OPW)
//   DEF_TIMEOUT - default RUN-cycle budget when MULT_ARB_TIMEOUT_EN is defined
//   arb_state_t - controller states
//   req_onehot  - requester index to one-hot vector
package mult_arb_pkg;

  localparam int unsigned NUM_REQ     = 2;
  localparam int unsigned DEF_OPW     = 8;
  localparam int unsigned DEF_TIMEOUT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  // Requester index to one-hot request/response vector.
  function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage : mult_arb_pkg

// File: rtl/mult_arbiter_rr_pick.sv
// rr_pick: combinational 2-way round-robin picker.
// Ports:
//   req   in  [1:0] pending requests
//   last  in        index of the requester served most recently
//   grant out [1:0] one-hot winner, or zero when nothing is requested
//   idx   out       winner index (0 when nothing is requested)
module rr_pick
  import mult_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last,
  output logic [NUM_REQ-1:0] grant,
  output logic               idx
);

  // A lone request always wins; on a tie the requester not served last wins.
  always_comb begin
    idx   = 1'b0;
    grant = '0;
    if (req == 2'b11) begin
      idx = ~last;
    end else begin
      idx = req[1];
    end
    if (req != '0) begin
      grant = req_onehot(idx);
    end
  end

endmodule : rr_pick

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one signed OPWxOPW shift-add multiplier core between two
// requesters. Operand pairs are accepted over valid/ready, arbitrated
// round-robin, sent to the core with a single start pulse, and the product is
// returned to the winning requester over valid/ready.
//
// Optional feature macro: MULT_ARB_TIMEOUT_EN
//   defined   - RUN is aborted after TIMEOUT cycles without mul_done; the
//               response then carries rsp_data=0 and rsp_err=1.
//   undefined - RUN waits indefinitely and rsp_err is tied low.
//
// Ports:
//   Clk, Reset              clock, synchronous active-high reset
//   req_valid[1:0]          request pending per requester
//   req_a, req_b[2*OPW-1:0] operands, requester i at bits [i*OPW +: OPW]
//   req_ready[1:0]          combinational grant in IDLE, at most one bit high
//   rsp_valid[1:0]          result available for the owner, at most one high
//   rsp_ready[1:0]          requester consumes result
//   rsp_data[2*OPW-1:0]     product, passed through unmodified
//   rsp_err                 result aborted by timeout
//   mul_start               one-cycle start pulse to the core
//   mul_a, mul_b[OPW-1:0]   operands to the core, held from start to done
//   mul_done, mul_result    completion pulse and product from the core
//   busy                    high in every state except IDLE
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned OPW     = DEF_OPW,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*OPW-1:0] req_a,
  input  logic [NUM_REQ*OPW-1:0] req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [2*OPW-1:0]       rsp_data,
  output logic                   rsp_err,
  output logic                   mul_start,
  output logic [OPW-1:0]         mul_a,
  output logic [OPW-1:0]         mul_b,
  input  logic                   mul_done,
  input  logic [2*OPW-1:0]       mul_result,
  output logic                   busy
);

  localparam int unsigned PW = 2 * OPW;

  // Degenerate configurations are rejected at elaboration.
  if (OPW == 0 || TIMEOUT == 0) begin : g_param_chk
    $error("mult_arbiter: OPW and TIMEOUT must be nonzero");
  end

  arb_state_t         state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_q,  last_d;
  logic [OPW-1:0]     mul_a_q, mul_a_d;
  logic [OPW-1:0]     mul_b_q, mul_b_d;
  logic [PW-1:0]      rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic               pick_idx;
  logic [OPW-1:0]     sel_a;
  logic [OPW-1:0]     sel_b;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rsp_err_q, rsp_err_d;
`endif

  rr_pick u_pick (
    .req   (req_valid),
    .last  (last_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // Operands of the current picker winner.
  assign sel_a = pick_idx ? req_a[2*OPW-1:OPW] : req_a[OPW-1:0];
  assign sel_b = pick_idx ? req_b[2*OPW-1:OPW] : req_b[OPW-1:0];

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Transaction registers; last starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      rsp_data_q <= '0;
    end else begin
      owner_q    <= owner_d;
      last_q     <= last_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      rsp_data_q <= rsp_data_d;
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  // RUN-cycle counter and abort flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end
`endif

  // Next-state and register updates.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    rsp_data_d = rsp_data_q;
`ifdef MULT_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    rsp_err_d  = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_grant != '0) begin
          owner_d = pick_idx;
          mul_a_d = sel_a;
          mul_b_d = sel_b;
          state_d = LOAD;
        end
      end
      LOAD: begin
`ifdef MULT_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = RUN;
      end
      RUN: begin
        if (mul_done) begin
          rsp_data_d = mul_result;
`ifdef MULT_ARB_TIMEOUT_EN
          rsp_err_d  = 1'b0;
`endif
          state_d    = RESP;
        end
`ifdef MULT_ARB_TIMEOUT_EN
        // The TIMEOUT-th RUN cycle without done aborts the operation.
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State-decoded outputs; the grant is withheld while Reset is asserted.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    mul_start = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (!Reset) begin
          req_ready = pick_grant;
        end
      end
      LOAD: begin
        mul_start = 1'b1;
      end
      RESP: begin
        rsp_valid = req_onehot(owner_q);
      end
      default: begin
      end
    endcase
  end

  assign mul_a    = mul_a_q;
  assign mul_b    = mul_b_q;
  assign rsp_data = rsp_data_q;

`ifdef MULT_ARB_TIMEOUT_EN
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule : mult_arbiter

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed bench for mult_arbiter with a transaction-level
// reference model checked every cycle and a bench-side multiplier core model.
// Define MULT_ARB_TIMEOUT_EN to also exercise the timeout path.
module tb_mult_arbiter;

  localparam int TIMEOUT = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [15:0] req_a = 16'h0000;
  logic [15:0] req_b = 16'h0000;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b11;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        mul_start;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic        mul_done = 1'b0;
  logic [15:0] mul_result = 16'h0000;
  logic        busy;

  mult_arbiter dut (
    .Clk        (clk),
    .Reset      (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_done   (mul_done),
    .mul_result (mul_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  // ---------------- bench-side multiplier core ----------------
  int          lat = 17;
  bit          core_hang = 1'b0;
  int          kill_req = 0, kill_seen = 0;
  int          inj_req = 0, inj_seen = 0;
  logic [15:0] inj_res = 16'h0000;
  int          core_cnt = 0;
  logic [15:0] core_prod = 16'h0000;

  always @(posedge clk) begin
    int pa, pb;
    #1;
    mul_done = 1'b0;
    if (kill_req != kill_seen) begin
      kill_seen = kill_req;
      core_cnt  = 0;
    end
    if (inj_req != inj_seen) begin
      inj_seen   = inj_req;
      mul_done   = 1'b1;
      mul_result = inj_res;
    end else if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        mul_done   = 1'b1;
        mul_result = core_prod;
      end
    end
    if (mul_start && !core_hang) begin
      pa        = int'($signed(mul_a));
      pb        = int'($signed(mul_b));
      core_prod = 16'(pa * pb);
      core_cnt  = lat;
    end
  end

  // ---------------- reference model and per-cycle compare ----------------
  bit          m_valid = 1'b0;
  bit          m_busy, m_have, m_err;
  int          m_owner, m_last, m_g, m_run;
  logic [7:0]  m_a, m_b;
  logic [15:0] m_data;

  int          glog[$];
  int          rlog_owner[$];
  logic [15:0] rlog_data[$];
  int          n_start = 0;
  int          n_rsp_cycles = 0;

  // Winner under the round-robin rule, or -1 when nothing is requested.
  function automatic int spec_winner(input logic [1:0] v, input int last);
    if (v == 2'b11) return 1 - last;
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
  endfunction

  always @(negedge clk) begin
    int w;
    logic [1:0] exp_rr, exp_rv;
    if (m_valid) begin
      w      = (rst || m_busy) ? -1 : spec_winner(req_valid, m_last);
      exp_rr = (w < 0) ? 2'b00 : ((w == 0) ? 2'b01 : 2'b10);
      exp_rv = m_have ? ((m_owner == 0) ? 2'b01 : 2'b10) : 2'b00;
      chk("req_ready", 32'(req_ready), 32'(exp_rr));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("mul_start", 32'(mul_start), 32'(m_busy && !m_have && (cyc == m_g + 1)));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      chk("rsp_data", 32'(rsp_data), 32'(m_data));
      chk("rsp_err", 32'(rsp_err), 32'(m_err));
      chk("mul_a", 32'(mul_a), 32'(m_a));
      chk("mul_b", 32'(mul_b), 32'(m_b));
    end
    if (req_ready != 2'b00) glog.push_back(req_ready[1] ? 1 : 0);
    if (mul_start) n_start++;
    if (rsp_valid != 2'b00) begin
      n_rsp_cycles++;
      if ((rsp_valid & rsp_ready) != 2'b00) begin
        rlog_owner.push_back(rsp_valid[1] ? 1 : 0);
        rlog_data.push_back(rsp_data);
      end
    end
    // advance the model to the next cycle
    if (rst) begin
      m_valid = 1'b1;
      m_busy  = 1'b0;
      m_have  = 1'b0;
      m_err   = 1'b0;
      m_owner = 0;
      m_last  = 1;
      m_g     = 0;
      m_run   = 0;
      m_a     = 8'h00;
      m_b     = 8'h00;
      m_data  = 16'h0000;
    end else if (m_valid) begin
      if (!m_busy) begin
        w = spec_winner(req_valid, m_last);
        if (w >= 0) begin
          m_busy  = 1'b1;
          m_owner = w;
          m_g     = cyc;
          m_run   = 0;
          m_a     = (w == 0) ? req_a[7:0] : req_a[15:8];
          m_b     = (w == 0) ? req_b[7:0] : req_b[15:8];
        end
      end else if (!m_have) begin
        if (cyc >= m_g + 2) begin
          if (mul_done) begin
            m_have = 1'b1;
            m_data = mul_result;
            m_err  = 1'b0;
          end
`ifdef MULT_ARB_TIMEOUT_EN
          else begin
            m_run++;
            if (m_run == TIMEOUT) begin
              m_have = 1'b1;
              m_data = 16'h0000;
              m_err  = 1'b1;
            end
          end
`endif
        end
      end else if (rsp_ready[m_owner]) begin
        m_busy = 1'b0;
        m_have = 1'b0;
        m_last = m_owner;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  // Present one request in the current (IDLE) cycle, then withdraw it.
  task automatic issue(input int who, input logic [7:0] a, input logic [7:0] b, output int g);
    if (who == 0) begin
      req_a[7:0] = a;
      req_b[7:0] = b;
      req_valid  = 2'b01;
    end else begin
      req_a[15:8] = a;
      req_b[15:8] = b;
      req_valid   = 2'b10;
    end
    g = cyc;
    tick();
    req_valid = 2'b00;
  endtask

  task automatic wait_rsp(input string name, input int max);
    for (int i = 0; i < max; i++) begin
      if (rsp_valid != 2'b00) return;
      tick();
    end
    chk({name, "_rsp_timeout"}, 32'(rsp_valid), 32'h1);
  endtask

  task automatic wait_idle(input string name, input int max);
    for (int i = 0; i < max; i++) begin
      if (!busy) return;
      tick();
    end
    chk({name, "_idle_timeout"}, 32'(busy), 32'h0);
  endtask

  initial begin
    int g, g2, s0, gb, rb, nr;

    do_reset(3);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_mul_start", 32'(mul_start), 32'h0);
    chk("rst_mul_a", 32'(mul_a), 32'h0);

    // single request: 7 * -3 = -21, core latency 17 -> response at grant+19
    lat = 17;
    s0  = n_start;
    issue(0, 8'h07, 8'hFD, g);
    wait_rsp("single", 60);
    chk("single_latency", 32'(cyc - g), 32'd19);
    chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("single_data", 32'(rsp_data), 32'h0000FFEB);
    tick();
    wait_idle("single", 10);
    chk("single_start_pulses", 32'(n_start - s0), 32'd1);

    // tie after reset: requester 0 first, then strict alternation
    do_reset(2);
    lat = 3;
    req_a = {8'h05, 8'h80};
    req_b = {8'h04, 8'h80};
    gb = glog.size();
    rb = rlog_data.size();
    req_valid = 2'b11;
    for (int i = 0; i < 400; i++) begin
      if (rlog_data.size() >= rb + 12) break;
      tick();
    end
    req_valid = 2'b00;
    wait_idle("tie", 30);
    nr = rlog_data.size() - rb;
    chk("tie_rsp_count_ok", 32'(nr >= 12 && glog.size() - gb >= 12), 32'h1);
    if (nr >= 12 && glog.size() - gb >= 12) begin
      for (int i = 0; i < 12; i++) begin
        chk("tie_grant", 32'(glog[gb + i]), 32'(i % 2));
        chk("tie_owner", 32'(rlog_owner[rb + i]), 32'(i % 2));
        chk("tie_data", 32'(rlog_data[rb + i]), (i % 2 == 1) ? 32'h0014 : 32'h4000);
      end
    end

    // backpressure: response held, pending requester not granted
    lat       = 5;
    rsp_ready = 2'b00;
    s0        = n_start;
    issue(1, 8'h03, 8'h05, g);
    req_a[7:0] = 8'h11;
    req_b[7:0] = 8'h02;
    req_valid  = 2'b01;
    wait_rsp("bp", 40);
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h2);
      chk("bp_data", 32'(rsp_data), 32'h000F);
      chk("bp_req_ready", 32'(req_ready), 32'h0);
      tick();
    end
    chk("bp_start_pulses", 32'(n_start - s0), 32'd1);
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    tick();
    tick();
    chk("bp_non_owner_ready", 32'(rsp_valid), 32'h2);
    rsp_ready = 2'b11;
    tick();
    chk("bp_released", 32'(busy), 32'h0);

    // reset in RUN, then a late done arriving in IDLE
    lat = 17;
    issue(0, 8'h02, 8'h03, g);
    while (cyc < g + 6) tick();
    chk("rr_in_run", 32'(busy), 32'h1);
    rst = 1'b1;
    kill_req++;
    tick();
    rst = 1'b0;
    nr  = n_rsp_cycles;
    s0  = n_start;
    chk("rr_busy", 32'(busy), 32'h0);
    chk("rr_rsp_data", 32'(rsp_data), 32'h0);
    chk("rr_mul_a", 32'(mul_a), 32'h0);
    chk("rr_mul_b", 32'(mul_b), 32'h0);
    tick();
    inj_res = 16'h1234;
    inj_req++;
    repeat (20) tick();
    chk("rr_no_rsp", 32'(n_rsp_cycles - nr), 32'h0);
    chk("rr_no_start", 32'(n_start - s0), 32'h0);
    chk("rr_idle", 32'(busy), 32'h0);
    chk("rr_data_kept", 32'(rsp_data), 32'h0);

    // stray done in IDLE and in RESP
    inj_res = 16'hBEEF;
    inj_req++;
    tick();
    tick();
    chk("stray_idle_busy", 32'(busy), 32'h0);
    chk("stray_idle_data", 32'(rsp_data), 32'h0);
    lat       = 4;
    rsp_ready = 2'b00;
    issue(1, 8'hFF, 8'hFF, g);
    wait_rsp("stray", 30);
    chk("stray_resp_data", 32'(rsp_data), 32'h0001);
    inj_req++;
    repeat (3) tick();
    chk("stray_resp_data_kept", 32'(rsp_data), 32'h0001);
    chk("stray_resp_valid", 32'(rsp_valid), 32'h2);
    rsp_ready = 2'b11;
    tick();
    chk("stray_resp_released", 32'(busy), 32'h0);

`ifdef MULT_ARB_TIMEOUT_EN
    // core never answers: abort after TIMEOUT RUN cycles, then a normal one
    core_hang = 1'b1;
    issue(0, 8'h04, 8'h04, g);
    wait_rsp("to", 80);
    chk("to_latency", 32'(cyc - g), 32'd34);
    chk("to_err", 32'(rsp_err), 32'h1);
    chk("to_data", 32'(rsp_data), 32'h0);
    tick();
    core_hang = 1'b0;
    lat       = 2;
    wait_idle("to", 10);
    issue(1, 8'h06, 8'h07, g2);
    wait_rsp("to_next", 30);
    chk("to_next_latency", 32'(cyc - g2), 32'd4);
    chk("to_next_err", 32'(rsp_err), 32'h0);
    chk("to_next_data", 32'(rsp_data), 32'h002A);
    tick();
`endif

    wait_idle("end", 20);
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_mult_arbiter
